// File: rtl/debug_keypad_pkg.sv
// Shared constants for the debug keypad: key indices, digit count and breakpoint width.
package debug_pkg;
    localparam int KEY_STEP         = 0;
    localparam int KEY_CURSOR       = 1;
    localparam int KEY_INC          = 2;
    localparam int KEY_ARM          = 3;
    localparam int N_DIGITS_DEFAULT = 6;
    localparam int BP_W             = 24;
    localparam int SEL_W            = 3;
endpackage

// File: rtl/debug_keypad_if.sv
// Board-side bundle of the debug keypad: raw keys, mode and fetch PC in; breakpoint and run control out.
interface debug_keypad_if;
    import debug_pkg::*;

    logic [3:0]       key_n;
    logic             debug;
    logic [31:0]      pcF;
    logic [BP_W-1:0]  bp_addr;
    logic [SEL_W-1:0] digit_sel;
    logic             bp_armed;
    logic             halt;
    logic             step_pulse;

    modport master (output key_n, debug, pcF,
                    input  bp_addr, digit_sel, bp_armed, halt, step_pulse);
    modport slave  (input  key_n, debug, pcF,
                    output bp_addr, digit_sel, bp_armed, halt, step_pulse);
endinterface

// File: rtl/debug_keypad_key_debouncer.sv
// One push-button: 2-flop synchronizer, stability counter, accepted level and a registered press pulse.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic pressed,
    output logic press_evt
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          r_sync1, r_sync2;
    logic          r_level, r_level_d;
    logic [CW-1:0] r_cnt;
    logic          r_evt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_level   <= 1'b1;
            r_level_d <= 1'b1;
            r_cnt     <= '0;
            r_evt     <= 1'b0;
        end else begin
            r_sync1   <= key_n;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            // Event fires one edge after the accepted level has dropped to pressed.
            r_evt     <= r_level_d & ~r_level;
            if (r_sync2 != r_level) begin
                if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign pressed   = ~r_level;
    assign press_evt = r_evt;
endmodule

// File: rtl/debug_keypad.sv
// Debug keypad: debounced keys edit a hex breakpoint nibble-wise and drive halt / single-step control.
module debug_keypad
    import debug_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int N_DIGITS        = N_DIGITS_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    debug_keypad_if.slave bus
);
    localparam int AW = 4 * N_DIGITS;

    logic [3:0]       w_evt;
    logic [3:0]       w_pressed;
    logic [3:0]       w_evt_g;
    logic [AW-1:0]    r_bp_addr;
    logic [AW-1:0]    w_bp_next;
    logic [SEL_W-1:0] r_digit_sel;
    logic             r_armed;
    logic             r_halt;
    logic             r_step;
    logic             r_match_d;
    logic             w_match;
    logic             w_halt_set;
    logic             w_unused_ok;

    for (genvar g = 0; g < 4; g++) begin : g_key
        key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk       (clk),
            .rst_n     (rst_n),
            .key_n     (bus.key_n[g]),
            .pressed   (w_pressed[g]),
            .press_evt (w_evt[g])
        );
    end

    assign w_evt_g     = w_evt & {4{bus.debug}};
    assign w_match     = r_armed & (bus.pcF[AW-1:0] == r_bp_addr);
    assign w_halt_set  = w_match & ~r_match_d;
    assign w_unused_ok = &{1'b0, bus.pcF[31:AW], w_pressed};

    // Increment edits the digit under the cursor as it was before any same-cycle move.
    always_comb begin
        w_bp_next = r_bp_addr;
        if (w_evt_g[KEY_INC]) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                if (r_digit_sel == SEL_W'(i))
                    w_bp_next[4*i +: 4] = r_bp_addr[4*i +: 4] + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bp_addr   <= '0;
            r_digit_sel <= '0;
            r_armed     <= 1'b0;
            r_halt      <= 1'b0;
            r_step      <= 1'b0;
            r_match_d   <= 1'b0;
        end else begin
            r_match_d <= w_match;
            r_bp_addr <= w_bp_next;
            r_step    <= w_evt_g[KEY_STEP];
            if (w_evt_g[KEY_CURSOR])
                r_digit_sel <= (r_digit_sel == SEL_W'(N_DIGITS - 1)) ? '0 : r_digit_sel + 1'b1;
            if (w_evt_g[KEY_ARM])
                r_armed <= ~r_armed;
            // Priority: leaving debug, then match set (gated by new arm state), disarm, step.
            if (!bus.debug)
                r_halt <= 1'b0;
            else if (w_halt_set)
                r_halt <= w_evt_g[KEY_ARM] ? ~r_armed : 1'b1;
            else if (w_evt_g[KEY_ARM] && r_armed)
                r_halt <= 1'b0;
            else if (w_evt_g[KEY_STEP])
                r_halt <= 1'b0;
        end
    end

    assign bus.bp_addr    = r_bp_addr;
    assign bus.digit_sel  = r_digit_sel;
    assign bus.bp_armed   = r_armed;
    assign bus.halt       = r_halt;
    assign bus.step_pulse = r_step;
endmodule

// File: tb/tb_debug_keypad.sv
// Bench for debug_keypad with a 4-cycle debounce: reference model feeds an expected-state queue.
module tb_debug_keypad;
    import debug_pkg::*;

    localparam int W = BP_W + SEL_W + 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    debug_keypad_if kif ();

    debug_keypad #(.DEBOUNCE_CYCLES(4), .N_DIGITS(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (kif.slave)
    );

    logic [W-1:0]     exp_q[$];
    logic [W-1:0]     exp_v;
    logic [W-1:0]     got_v;
    int               n_checks = 0;
    int               n_pass   = 0;
    logic [BP_W-1:0]  m_bp;
    logic [SEL_W-1:0] m_sel;
    logic             m_armed;
    logic             m_halt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] snap();
        return {kif.bp_addr, kif.digit_sel, kif.bp_armed, kif.halt};
    endfunction

    function automatic void push_exp();
        exp_q.push_back({m_bp, m_sel, m_armed, m_halt});
    endfunction

    // Reference behaviour of one accepted press while debug is high.
    function automatic void model_press(input int k);
        logic [BP_W-1:0] t;
        t = m_bp;
        case (k)
            KEY_STEP:   m_halt = 1'b0;
            KEY_CURSOR: m_sel = (m_sel == 3'd5) ? 3'd0 : m_sel + 3'd1;
            KEY_INC: begin
                t[4*m_sel +: 4] = t[4*m_sel +: 4] + 4'd1;
                m_bp = t;
            end
            default: begin
                m_armed = ~m_armed;
                if (!m_armed) m_halt = 1'b0;
            end
        endcase
    endfunction

    task automatic press(input int k, output int pulses);
        pulses = 0;
        kif.key_n[k] = 1'b0;
        repeat (10) begin tick(); if (kif.step_pulse) pulses++; end
        kif.key_n[k] = 1'b1;
        repeat (10) begin tick(); if (kif.step_pulse) pulses++; end
    endtask

    task automatic test_reset();
        int pulses;
        pulses = 0;
        rst_n = 1'b0;
        kif.key_n = 4'hF; kif.debug = 1'b1; kif.pcF = 32'h0;
        m_bp = '0; m_sel = '0; m_armed = 1'b0; m_halt = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        push_exp();
        repeat (20) begin tick(); if (kif.step_pulse) pulses++; end
        exp_v = exp_q.pop_front(); got_v = snap(); n_checks++;
        if (got_v !== exp_v) $display("FAIL reset_state got %h exp %h", got_v, exp_v);
        else n_pass++;
        n_checks++;
        if (pulses != 0) $display("FAIL reset_no_pulse got %0d exp 0", pulses);
        else n_pass++;
    endtask

    task automatic test_debounce();
        kif.key_n[KEY_INC] = 1'b0;
        repeat (3) tick();
        kif.key_n[KEY_INC] = 1'b1;
        push_exp();
        repeat (10) tick();
        exp_v = exp_q.pop_front(); got_v = snap(); n_checks++;
        if (got_v !== exp_v) $display("FAIL glitch_ignored got %h exp %h", got_v, exp_v);
        else n_pass++;
        // Low first sampled at edge 0; update must appear after edge 7, not edge 6.
        kif.key_n[KEY_INC] = 1'b0;
        push_exp();
        repeat (7) tick();
        exp_v = exp_q.pop_front(); got_v = snap(); n_checks++;
        if (got_v !== exp_v) $display("FAIL latency_edge6 got %h exp %h", got_v, exp_v);
        else n_pass++;
        model_press(KEY_INC);
        push_exp();
        tick();
        exp_v = exp_q.pop_front(); got_v = snap(); n_checks++;
        if (got_v !== exp_v) $display("FAIL latency_edge7 got %h exp %h", got_v, exp_v);
        else n_pass++;
        repeat (3) tick();
        kif.key_n[KEY_INC] = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_inc_cursor();
        int pulses;
        for (int i = 0; i < 15; i++) begin
            model_press(KEY_INC);
            press(KEY_INC, pulses);
        end
        push_exp();
        exp_v = exp_q.pop_front(); got_v = snap(); n_checks++;
        if (got_v !== exp_v || kif.bp_addr !== 24'h0)
            $display("FAIL inc_wrap_no_carry got %h exp %h", got_v, exp_v);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            model_press(KEY_CURSOR);
            push_exp();
            press(KEY_CURSOR, pulses);
            exp_v = exp_q.pop_front(); got_v = snap(); n_checks++;
            if (got_v !== exp_v) $display("FAIL cursor_step%0d got %h exp %h", i, got_v, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_halt_step();
        int pulses;
        model_press(KEY_CURSOR); press(KEY_CURSOR, pulses);
        for (int i = 0; i < 4; i++) begin model_press(KEY_INC); press(KEY_INC, pulses); end
        for (int i = 0; i < 5; i++) begin model_press(KEY_CURSOR); press(KEY_CURSOR, pulses); end
        kif.pcF = 32'h0000_003C;
        model_press(KEY_ARM);
        push_exp();
        press(KEY_ARM, pulses);
        exp_v = exp_q.pop_front(); got_v = snap(); n_checks++;
        if (got_v !== exp_v || kif.bp_addr !== 24'h000040)
            $display("FAIL armed_0x40 got %h exp %h", got_v, exp_v);
        else n_pass++;
        kif.pcF = 32'h0000_0040;
        m_halt = 1'b1;
        push_exp();
        tick();
        exp_v = exp_q.pop_front(); got_v = snap(); n_checks++;
        if (got_v !== exp_v) $display("FAIL match_halt got %h exp %h", got_v, exp_v);
        else n_pass++;
        model_press(KEY_STEP);
        push_exp();
        press(KEY_STEP, pulses);
        n_checks++;
        if (pulses != 1) $display("FAIL step_width got %0d exp 1", pulses);
        else n_pass++;
        repeat (5) tick();
        exp_v = exp_q.pop_front(); got_v = snap(); n_checks++;
        if (got_v !== exp_v) $display("FAIL no_rehalt got %h exp %h", got_v, exp_v);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        kif.pcF = 32'h0000_003C;
        repeat (3) tick();
        kif.key_n[KEY_STEP] = 1'b0;
        repeat (7) tick();
        kif.pcF = 32'h0000_0040;
        m_halt = 1'b1;
        push_exp();
        tick();
        exp_v = exp_q.pop_front(); got_v = snap(); n_checks++;
        if (got_v !== exp_v || kif.step_pulse !== 1'b1)
            $display("FAIL step_vs_match got %h/%b exp %h/1", got_v, kif.step_pulse, exp_v);
        else n_pass++;
        repeat (3) tick();
        kif.key_n[KEY_STEP] = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_debug_off();
        int pulses;
        int total;
        total = 0;
        kif.debug = 1'b0;
        m_halt = 1'b0;
        push_exp();
        tick();
        exp_v = exp_q.pop_front(); got_v = snap(); n_checks++;
        if (got_v !== exp_v) $display("FAIL debug_off_clears_halt got %h exp %h", got_v, exp_v);
        else n_pass++;
        push_exp();
        for (int k = 0; k < 4; k++) begin press(k, pulses); total += pulses; end
        exp_v = exp_q.pop_front(); got_v = snap(); n_checks++;
        if (got_v !== exp_v) $display("FAIL debug_off_ignored got %h exp %h", got_v, exp_v);
        else n_pass++;
        n_checks++;
        if (total != 0) $display("FAIL debug_off_step got %0d exp 0", total);
        else n_pass++;
        kif.debug = 1'b1;
        kif.pcF = 32'h0000_003C;
        repeat (2) tick();
        kif.pcF = 32'h0000_0040;
        tick();
        n_checks++;
        if (kif.halt !== 1'b1) $display("FAIL rehalt got %b exp 1", kif.halt);
        else n_pass++;
        rst_n = 1'b0;
        m_bp = '0; m_sel = '0; m_armed = 1'b0; m_halt = 1'b0;
        push_exp();
        tick();
        exp_v = exp_q.pop_front(); got_v = snap(); n_checks++;
        if (got_v !== exp_v || kif.step_pulse !== 1'b0)
            $display("FAIL reset_mid_halt got %h exp %h", got_v, exp_v);
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_inc_cursor();
        test_halt_step();
        test_simultaneous();
        test_debug_off();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL queue_drained got %0d exp 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
